// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline register.
// The optional stall counter is enabled with PIPE_STALL_CNT_EN.
package pipe_pkg;

    localparam int unsigned STATE_W     = 2;
    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [STATE_W-1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } pipe_state_t;

    // Saturating increment for the stall counter
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/reg_param.sv
// WIDTH-bit enable register with asynchronous active-low clear to RESET_VAL.
module reg_param #(
    parameter int unsigned         WIDTH     = 65,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q <= RESET_VAL;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Single pipeline stage with valid/ready handshake and a one-entry skid buffer.
// Optional stall counter output enabled by defining PIPE_STALL_CNT_EN.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int unsigned         WIDTH     = 65,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
`ifdef PIPE_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    input  logic                   flush
);

    pipe_state_t      state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic             main_en, skid_en, main_sel_skid;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    // Next-state and data-enable decode; flush overrides every handshake
    always_comb begin
        state_d       = state_q;
        main_en       = 1'b0;
        skid_en       = 1'b0;
        main_sel_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    main_en = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (in_valid && out_ready) begin
                    main_en = 1'b1;
                end else if (in_valid) begin
                    skid_en = 1'b1;
                    state_d = SKID;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (out_ready) begin
                    main_en       = 1'b1;
                    main_sel_skid = 1'b1;
                    state_d       = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    assign main_d = main_sel_skid ? skid_q : in_data;

    // Handshake outputs are pre-decoded from the next state so they leave a flop
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != SKID);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    reg_param #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .clr_n (clr_n),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    reg_param #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk   (clk),
        .clr_n (clr_n),
        .en_i  (skid_en),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_cnt_q <= '0;
        end else if (flush) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
